ifu_fetch: RTL and testbench

Instruction fetch unit for the single-issue RV32 core. It owns the PC, issues one-outstanding fetch requests to instruction memory, and predecodes each returned word to predict the next PC. It then presents `instr`/`pc`/`prdt_taken` to `exu_decode` through a one-entry valid/ready buffer. It accepts redirects from the EXU on mispredicts and on `jalr`.

---
 rtl/ifu_fetch_pkg.sv | 33 +++
 rtl/ifu_fetch_minidec.sv | 62 ++++++
 rtl/ifu_fetch.sv | 200 ++++++++++++++++++++
 tb/tb_ifu_fetch.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_fetch_pkg.sv
// ----------------------------------------------------------------------------
// ifu_fetch_pkg
// Shared constants for the instruction fetch unit: reset PC, the RV32 opcodes
// the predecoder cares about, the fetch FSM state encoding, and helpers that
// extract the sign-extended J- and B-type immediates (the same field layout
// exu_decode uses).
// ----------------------------------------------------------------------------
package ifu_fetch_pkg;

    localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // REQ: request driven, WAIT: one request outstanding, HALT: parked after a fault
    typedef enum logic [1:0] {
        IFU_ST_REQ  = 2'd0,
        IFU_ST_WAIT = 2'd1,
        IFU_ST_HALT = 2'd2
    } ifu_state_e;

    // J-type immediate: {imm[20], imm[10:1], imm[11], imm[19:12]} in instr[31:12]
    function automatic logic [31:0] j_imm(input logic [31:0] instr);
        return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction

    // B-type immediate: imm[12|10:5] in instr[31:25], imm[4:1|11] in instr[11:7]
    function automatic logic [31:0] b_imm(input logic [31:0] instr);
        return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/ifu_fetch_minidec.sv
// ----------------------------------------------------------------------------
// ifu_minidec
// Combinational predecoder. Predicts the successor of a fetched word:
//   jal             -> taken, pc + J-imm
//   backward branch -> taken, pc + B-imm (sign bit of the offset set)
//   anything else   -> not taken, pc + 4
// All arithmetic wraps modulo 2^PC_SIZE.
// Ports:
//   instr      in   fetched instruction word
//   pc         in   address of that word
//   prdt_taken out  predicted taken
//   next_pc    out  predicted next fetch address
// ----------------------------------------------------------------------------
module ifu_minidec
    import ifu_fetch_pkg::*;
#(
    parameter int PC_SIZE = 32
) (
    input  logic [31:0]        instr,
    input  logic [PC_SIZE-1:0] pc,
    output logic               prdt_taken,
    output logic [PC_SIZE-1:0] next_pc
);

    logic [31:0] j_imm_s;
    logic [31:0] b_imm_s;

    assign j_imm_s = j_imm(instr);
    assign b_imm_s = b_imm(instr);

    // Static prediction from the opcode and the branch offset direction
    always_comb begin
        prdt_taken = 1'b0;
        next_pc    = pc + PC_SIZE'(32'd4);
        case (instr[6:0])
            OPC_JAL: begin
                prdt_taken = 1'b1;
                next_pc    = pc + PC_SIZE'(signed'(j_imm_s));
            end
            OPC_BRANCH: begin
                // backward-taken / forward-not-taken
                if (instr[31]) begin
                    prdt_taken = 1'b1;
                    next_pc    = pc + PC_SIZE'(signed'(b_imm_s));
                end else begin
                    prdt_taken = 1'b0;
                    next_pc    = pc + PC_SIZE'(32'd4);
                end
            end
            // target is register-based, resolved by the EXU through a redirect
            OPC_JALR: begin
                prdt_taken = 1'b0;
                next_pc    = pc + PC_SIZE'(32'd4);
            end
            default: begin
                prdt_taken = 1'b0;
                next_pc    = pc + PC_SIZE'(32'd4);
            end
        endcase
    end

endmodule

// File: rtl/ifu_fetch.sv
// ----------------------------------------------------------------------------
// ifu_fetch
// Instruction fetch unit: owns the fetch PC, keeps at most one request
// outstanding to instruction memory, predecodes each response to choose the
// next PC and hands {instr, pc, prdt_taken, err} to decode through a one-entry
// valid/ready buffer. EXU redirects flush the buffer and retarget fetch.
// Ports:
//   clk, rst (async, active-low)
//   ifu_req_valid/ready/addr       fetch request channel
//   ifu_rsp_valid/ready/instr/err  fetch response channel
//   o_ifu_valid/ready, o_instr, o_pc, o_prdt_taken, o_err   decode side
//   redirect_valid, redirect_pc    EXU flush / new fetch target
// ----------------------------------------------------------------------------
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter int                 PC_SIZE    = 32,
    parameter int                 INSTR_SIZE = 32,
    parameter logic [PC_SIZE-1:0] RESET_PC   = PC_SIZE'(IFU_RESET_PC)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  ifu_req_valid,
    input  logic                  ifu_req_ready,
    output logic [PC_SIZE-1:0]    ifu_req_addr,
    input  logic                  ifu_rsp_valid,
    output logic                  ifu_rsp_ready,
    input  logic [INSTR_SIZE-1:0] ifu_rsp_instr,
    input  logic                  ifu_rsp_err,
    output logic                  o_ifu_valid,
    input  logic                  o_ifu_ready,
    output logic [INSTR_SIZE-1:0] o_instr,
    output logic [PC_SIZE-1:0]    o_pc,
    output logic                  o_prdt_taken,
    output logic                  o_err,
    input  logic                  redirect_valid,
    input  logic [PC_SIZE-1:0]    redirect_pc
);

    localparam logic [PC_SIZE-1:0] WORD_MASK = {{(PC_SIZE-2){1'b1}}, 2'b00};

    ifu_state_e            state_q, state_d;
    logic [PC_SIZE-1:0]    pc_q, pc_d;
    logic                  drop_q, drop_d;
    logic                  o_valid_q, o_valid_d;
    logic [INSTR_SIZE-1:0] o_instr_q, o_instr_d;
    logic [PC_SIZE-1:0]    o_pc_q, o_pc_d;
    logic                  o_prdt_q, o_prdt_d;
    logic                  o_err_q, o_err_d;

    logic                  req_fire_s;
    logic                  rsp_fire_s;
    logic                  dec_taken_s;
    logic [PC_SIZE-1:0]    dec_next_s;
    logic [PC_SIZE-1:0]    redirect_pc_s;

    assign req_fire_s    = ifu_req_valid & ifu_req_ready;
    assign rsp_fire_s    = ifu_rsp_valid & ifu_rsp_ready;
    assign redirect_pc_s = redirect_pc & WORD_MASK;

    ifu_minidec #(.PC_SIZE(PC_SIZE)) u_minidec (
        .instr      (ifu_rsp_instr),
        .pc         (pc_q),
        .prdt_taken (dec_taken_s),
        .next_pc    (dec_next_s)
    );

    // State, PC, drop flag and decode buffer registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IFU_ST_REQ;
            pc_q      <= RESET_PC;
            drop_q    <= 1'b0;
            o_valid_q <= 1'b0;
            o_instr_q <= {INSTR_SIZE{1'b0}};
            o_pc_q    <= {PC_SIZE{1'b0}};
            o_prdt_q  <= 1'b0;
            o_err_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            drop_q    <= drop_d;
            o_valid_q <= o_valid_d;
            o_instr_q <= o_instr_d;
            o_pc_q    <= o_pc_d;
            o_prdt_q  <= o_prdt_d;
            o_err_q   <= o_err_d;
        end
    end

    // Next state, fetch PC and drop flag; redirect overrides everything
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        drop_d  = drop_q;
        case (state_q)
            IFU_ST_REQ: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc_s;
                    // a request accepted on this edge still fetches the old
                    // target, so its response has to be thrown away
                    if (req_fire_s) begin
                        state_d = IFU_ST_WAIT;
                        drop_d  = 1'b1;
                    end else begin
                        state_d = IFU_ST_REQ;
                    end
                end else if (req_fire_s) begin
                    state_d = IFU_ST_WAIT;
                    drop_d  = 1'b0;
                end else begin
                    state_d = IFU_ST_REQ;
                end
            end
            IFU_ST_WAIT: begin
                if (rsp_fire_s) begin
                    drop_d = 1'b0;
                    if (redirect_valid) begin
                        pc_d    = redirect_pc_s;
                        state_d = IFU_ST_REQ;
                    end else if (drop_q) begin
                        state_d = IFU_ST_REQ;
                    end else if (ifu_rsp_err) begin
                        state_d = IFU_ST_HALT;
                    end else begin
                        pc_d    = dec_next_s & WORD_MASK;
                        state_d = IFU_ST_REQ;
                    end
                end else if (redirect_valid) begin
                    pc_d    = redirect_pc_s;
                    drop_d  = 1'b1;
                    state_d = IFU_ST_WAIT;
                end else begin
                    state_d = IFU_ST_WAIT;
                end
            end
            IFU_ST_HALT: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc_s;
                    state_d = IFU_ST_REQ;
                end else begin
                    state_d = IFU_ST_HALT;
                end
            end
            default: begin
                state_d = IFU_ST_REQ;
                pc_d    = pc_q;
                drop_d  = 1'b0;
            end
        endcase
    end

    // Handshake outputs decoded from the state
    always_comb begin
        ifu_req_valid = 1'b0;
        ifu_rsp_ready = 1'b0;
        // gating with rst keeps the request low while reset is held
        if (state_q == IFU_ST_REQ) begin
            ifu_req_valid = rst;
        end else begin
            ifu_req_valid = 1'b0;
        end
        // a response being dropped never needs buffer space
        if (state_q == IFU_ST_WAIT) begin
            ifu_rsp_ready = drop_q | ~o_valid_q | o_ifu_ready;
        end else begin
            ifu_rsp_ready = 1'b0;
        end
    end

    // Decode buffer: flush on redirect, load on a kept response, drain on consume
    always_comb begin
        o_valid_d = o_valid_q;
        o_instr_d = o_instr_q;
        o_pc_d    = o_pc_q;
        o_prdt_d  = o_prdt_q;
        o_err_d   = o_err_q;
        if (redirect_valid) begin
            o_valid_d = 1'b0;
        end else if (rsp_fire_s && !drop_q) begin
            o_valid_d = 1'b1;
            o_instr_d = ifu_rsp_instr;
            o_pc_d    = pc_q;
            o_prdt_d  = dec_taken_s & ~ifu_rsp_err;
            o_err_d   = ifu_rsp_err;
        end else if (o_ifu_ready) begin
            o_valid_d = 1'b0;
        end else begin
            o_valid_d = o_valid_q;
        end
    end

    assign ifu_req_addr = pc_q;
    assign o_ifu_valid  = o_valid_q;
    assign o_instr      = o_instr_q;
    assign o_pc         = o_pc_q;
    assign o_prdt_taken = o_prdt_q;
    assign o_err        = o_err_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// ----------------------------------------------------------------------------
// tb_ifu_fetch
// Drives ifu_fetch with a one-outstanding memory model and a decode-side
// consumer. Predecode cases come from a vector table; redirect, backpressure,
// fault and reset-in-flight cases are hand-written sequences; a randomized run
// compares every consumed instruction against a program-level model that
// knows each word's kind and offset.
// ----------------------------------------------------------------------------
module tb_ifu_fetch;

    localparam logic [31:0] RPC = 32'h8000_0000;

    logic        clk;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready;
    logic [31:0] ifu_req_addr;
    logic        ifu_rsp_valid, ifu_rsp_ready;
    logic [31:0] ifu_rsp_instr;
    logic        ifu_rsp_err;
    logic        o_ifu_valid, o_ifu_ready;
    logic [31:0] o_instr, o_pc;
    logic        o_prdt_taken, o_err;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    ifu_fetch dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready),
        .ifu_rsp_instr(ifu_rsp_instr), .ifu_rsp_err(ifu_rsp_err),
        .o_ifu_valid(o_ifu_valid), .o_ifu_ready(o_ifu_ready), .o_instr(o_instr), .o_pc(o_pc),
        .o_prdt_taken(o_prdt_taken), .o_err(o_err),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; logic [31:0] addr; } req_t;
    typedef struct { int cyc; logic [31:0] pc; logic [31:0] instr; logic prdt; logic err; } dec_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; logic [31:0] next; logic taken; } vec_t;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // memory model and consumer knobs
    bit          pend;
    logic [31:0] pend_addr;
    int          cnt;
    int          lat_min, lat_max, req_pct, dec_mode;
    logic [31:0] dmem [logic [31:0]];
    bit          errmap [logic [31:0]];

    // random program: kind 0 addi, 1 jal, 2 branch, 3 jalr
    int          kind [64];
    int          offs [64];
    logic [31:0] word [64];

    req_t req_q[$];
    dec_t dec_q[$];
    int   rsp_q[$];

    bit          chk_trace;
    logic [31:0] exp_pc;
    int          consumed;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] enc_jal(input int o, input logic [4:0] rd);
        logic [20:0] m;
        m = o[20:0];
        return {m[20], m[10:1], m[11], m[19:12], rd, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_br(input int o, input logic [2:0] f3,
                                           input logic [4:0] rs1, input logic [4:0] rs2);
        logic [12:0] m;
        m = o[12:0];
        return {m[12], m[10:5], rs2, rs1, f3, m[4:1], m[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (dmem.exists(a)) return dmem[a];
        else return word[int'((a >> 2) & 32'd63)];
    endfunction

    function automatic logic model_taken(input logic [31:0] pc);
        int i;
        i = int'((pc >> 2) & 32'd63);
        if (kind[i] == 1) return 1'b1;
        if (kind[i] == 2) return offs[i] < 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_next(input logic [31:0] pc);
        int i;
        i = int'((pc >> 2) & 32'd63);
        if (model_taken(pc)) return pc + 32'(offs[i]);
        return pc + 32'd4;
    endfunction

    function automatic logic [31:0] req_addr_at(input int i);
        if (req_q.size() > i) return req_q[i].addr;
        return 32'hDEAD_BEEF;
    endfunction

    function automatic int req_cyc_at(input int i);
        if (req_q.size() > i) return req_q[i].cyc;
        return -1;
    endfunction

    function automatic logic [31:0] dec_pc_at(input int i);
        if (dec_q.size() > i) return dec_q[i].pc;
        return 32'hDEAD_BEEF;
    endfunction

    // One clock: drive inputs at the negedge, resolve handshakes, advance.
    task automatic step(input bit redir, input logic [31:0] rpc);
        bit req_fire, rsp_fire, dec_fire;
        redirect_valid = redir;
        redirect_pc    = rpc;
        ifu_req_ready  = ($urandom_range(99) < req_pct);
        o_ifu_ready    = (dec_mode == 1) ? 1'b1 : (dec_mode == 2) ? ($urandom_range(99) < 60) : 1'b0;
        ifu_rsp_valid  = pend && (cnt == 0);
        ifu_rsp_instr  = ifu_rsp_valid ? mem_word(pend_addr) : 32'h0;
        ifu_rsp_err    = ifu_rsp_valid && errmap.exists(pend_addr);
        #1;
        req_fire = ifu_req_valid && ifu_req_ready;
        rsp_fire = ifu_rsp_valid && ifu_rsp_ready;
        dec_fire = o_ifu_valid && o_ifu_ready;
        if (dec_fire) begin
            dec_q.push_back('{cyc, o_pc, o_instr, o_prdt_taken, o_err});
            if (chk_trace) begin
                chk("trace_pc", o_pc, exp_pc);
                chk("trace_instr", o_instr, mem_word(exp_pc));
                chk("trace_prdt", {31'd0, o_prdt_taken}, {31'd0, model_taken(exp_pc)});
                chk("trace_err", {31'd0, o_err}, 32'd0);
                exp_pc = model_next(exp_pc);
                consumed++;
            end
        end
        if (rsp_fire) begin
            pend = 1'b0;
            rsp_q.push_back(cyc);
        end
        if (req_fire) begin
            chk("one_outstanding", {31'd0, pend}, 32'd0);
            req_q.push_back('{cyc, ifu_req_addr});
            pend      = 1'b1;
            pend_addr = ifu_req_addr;
            cnt       = $urandom_range(lat_max, lat_min);
        end else if (pend && cnt > 0) begin
            cnt--;
        end
        @(posedge clk);
        @(negedge clk);
        redirect_valid = 1'b0;
        cyc++;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req_valid"}, {31'd0, ifu_req_valid}, 32'd0);
        chk({tag, "_req_addr"}, ifu_req_addr, RPC);
        chk({tag, "_rsp_ready"}, {31'd0, ifu_rsp_ready}, 32'd0);
        chk({tag, "_o_valid"}, {31'd0, o_ifu_valid}, 32'd0);
        chk({tag, "_o_instr"}, o_instr, 32'd0);
        chk({tag, "_o_pc"}, o_pc, 32'd0);
        chk({tag, "_o_prdt"}, {31'd0, o_prdt_taken}, 32'd0);
        chk({tag, "_o_err"}, {31'd0, o_err}, 32'd0);
    endtask

    task automatic do_reset(input bit check_vals);
        rst            = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        ifu_req_ready  = 1'b0;
        ifu_rsp_valid  = 1'b0;
        ifu_rsp_instr  = 32'h0;
        ifu_rsp_err    = 1'b0;
        o_ifu_ready    = 1'b0;
        pend           = 1'b0;
        chk_trace      = 1'b0;
        req_q.delete();
        dec_q.delete();
        rsp_q.delete();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        if (check_vals) chk_reset_vals("reset");
        rst = 1'b1;
        #1;
    endtask

    vec_t tbl [7];

    initial begin
        logic [31:0] snap_pc, snap_instr;
        int          guard;

        clk = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 64; i++) begin
            kind[i] = $urandom_range(3);
            offs[i] = (int'($urandom_range(32)) - 16) * 4;
            case (kind[i])
                1: word[i] = enc_jal(offs[i], 5'($urandom_range(31)));
                2: word[i] = enc_br(offs[i], 3'($urandom_range(7)), 5'($urandom_range(31)),
                                    5'($urandom_range(31)));
                3: word[i] = {12'($urandom_range(4095)), 5'($urandom_range(31)), 3'b000,
                              5'($urandom_range(31)), 7'b1100111};
                default: word[i] = {12'($urandom_range(4095)), 5'($urandom_range(31)), 3'b000,
                                    5'($urandom_range(31)), 7'b0010011};
            endcase
        end

        tbl[0] = '{32'h8000_0000, 32'h0000_0013, 32'h8000_0004, 1'b0};
        tbl[1] = '{32'h8000_0010, 32'hFF9F_F06F, 32'h8000_0008, 1'b1};
        tbl[2] = '{32'h8000_0020, 32'h0000_0463, 32'h8000_0024, 1'b0};
        tbl[3] = '{32'h8000_0020, 32'hFE00_0EE3, 32'h8000_001C, 1'b1};
        tbl[4] = '{32'h8000_0030, 32'h0000_80E7, 32'h8000_0034, 1'b0};
        tbl[5] = '{32'hFFFF_FFFC, 32'h0080_006F, 32'h0000_0004, 1'b1};
        tbl[6] = '{32'h0000_0000, 32'hFE00_0EE3, 32'hFFFF_FFFC, 1'b1};

        // reset values, first request, zero-wait throughput
        lat_min = 0; lat_max = 0; req_pct = 100; dec_mode = 1;
        do_reset(1'b1);
        chk("first_req_valid", {31'd0, ifu_req_valid}, 32'd1);
        chk("first_req_addr", ifu_req_addr, RPC);
        for (int i = 0; i < 40; i++) step(1'b0, 32'h0);
        chk("throughput", 32'(dec_q.size()), 32'd19);
        chk("tp_first_pc", dec_pc_at(0), RPC);

        // predecode vectors, each entered by a redirect from REQ
        foreach (tbl[k]) begin
            do_reset(1'b0);
            dmem.delete();
            dmem[tbl[k].pc] = tbl[k].instr;
            req_pct = 0;
            step(1'b1, tbl[k].pc);
            req_pct = 100;
            for (int i = 0; i < 6; i++) step(1'b0, 32'h0);
            chk("tbl_req0", req_addr_at(0), tbl[k].pc);
            chk("tbl_req0_cyc", 32'(req_cyc_at(0)), 32'(cyc - 6));
            chk("tbl_next", req_addr_at(1), tbl[k].next);
            chk("tbl_pc", dec_pc_at(0), tbl[k].pc);
            chk("tbl_instr", (dec_q.size() > 0) ? dec_q[0].instr : 32'hDEAD_BEEF, tbl[k].instr);
            chk("tbl_prdt", (dec_q.size() > 0) ? {31'd0, dec_q[0].prdt} : 32'hDEAD_BEEF,
                {31'd0, tbl[k].taken});
        end
        dmem.delete();

        // redirect during WAIT (before response) and with the response
        for (int v = 0; v < 2; v++) begin
            logic [31:0] tgt;
            tgt = (v == 0) ? 32'h8000_0100 : 32'h8000_0300;
            lat_min = (v == 0) ? 2 : 0; lat_max = lat_min;
            do_reset(1'b0);
            step(1'b0, 32'h0);
            step(1'b1, tgt);
            for (int i = 0; i < 10; i++) step(1'b0, 32'h0);
            chk("redir_req", req_addr_at(1), tgt);
            chk("redir_req_cyc", 32'(req_cyc_at(1)), (rsp_q.size() > 0) ? 32'(rsp_q[0] + 1) : 32'hDEAD_BEEF);
            chk("redir_first_dec", dec_pc_at(0), tgt);
        end

        // backpressure: buffer full, decode stalled 5 cycles
        lat_min = 0; lat_max = 0; dec_mode = 0;
        do_reset(1'b0);
        dmem[RPC]         = 32'h0000_0013;
        dmem[RPC + 32'd4] = 32'h0010_0093;
        step(1'b0, 32'h0);
        step(1'b0, 32'h0);
        chk("bp_valid", {31'd0, o_ifu_valid}, 32'd1);
        snap_pc    = o_pc;
        snap_instr = o_instr;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 32'h0);
            chk("bp_stable_pc", o_pc, snap_pc);
            chk("bp_stable_instr", o_instr, snap_instr);
            chk("bp_rsp_ready", {31'd0, ifu_rsp_ready}, 32'd0);
        end
        chk("bp_rsp_held", 32'(rsp_q.size()), 32'd1);
        dec_mode = 1;
        step(1'b0, 32'h0);
        chk("bp_refill_rsp", 32'(rsp_q.size()), 32'd2);
        chk("bp_refill_valid", {31'd0, o_ifu_valid}, 32'd1);
        chk("bp_refill_pc", o_pc, RPC + 32'd4);
        chk("bp_refill_instr", o_instr, 32'h0010_0093);
        chk("bp_consumed_pc", dec_pc_at(0), RPC);
        dmem.delete();

        // fetch fault: halt until redirect
        do_reset(1'b0);
        dmem[RPC]   = 32'hFF9F_F06F;
        errmap[RPC] = 1'b1;
        for (int i = 0; i < 10; i++) step(1'b0, 32'h0);
        chk("flt_err", (dec_q.size() > 0) ? {31'd0, dec_q[0].err} : 32'hDEAD_BEEF, 32'd1);
        chk("flt_prdt", (dec_q.size() > 0) ? {31'd0, dec_q[0].prdt} : 32'hDEAD_BEEF, 32'd0);
        chk("flt_instr", (dec_q.size() > 0) ? dec_q[0].instr : 32'hDEAD_BEEF, 32'hFF9F_F06F);
        chk("flt_nreq", 32'(req_q.size()), 32'd1);
        chk("flt_req_valid", {31'd0, ifu_req_valid}, 32'd0);
        step(1'b1, 32'h8000_0200);
        chk("flt_resume_valid", {31'd0, ifu_req_valid}, 32'd1);
        chk("flt_resume_addr", ifu_req_addr, 32'h8000_0200);
        step(1'b0, 32'h0);
        chk("flt_resume_req", req_addr_at(1), 32'h8000_0200);
        errmap.delete();
        dmem.delete();

        // reset while WAIT with a full buffer
        dec_mode = 0;
        do_reset(1'b0);
        step(1'b0, 32'h0);
        step(1'b0, 32'h0);
        step(1'b0, 32'h0);
        chk("mid_buf_full", {31'd0, o_ifu_valid}, 32'd1);
        rst = 1'b0;
        #1;
        chk_reset_vals("midwait");
        pend = 1'b0;

        // randomized run against the program model
        lat_min = 0; lat_max = 3; req_pct = 70; dec_mode = 2;
        do_reset(1'b0);
        chk_trace = 1'b1;
        exp_pc    = RPC;
        consumed  = 0;
        guard     = 0;
        while (consumed < 150 && guard < 4000) begin
            step(1'b0, 32'h0);
            guard++;
        end
        chk("rand_progress", {31'd0, consumed >= 150}, 32'd1);
        chk_trace = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
